// File: rtl/seq_mag_comp.sv
// rtl/seq_mag_comp.sv - sequential MSB-first magnitude comparator, DIGIT bits per clock, early exit.
// Define SEQ_MAG_COMP_SIGNED_EN for two's-complement operands.
module seq_mag_comp #(
    parameter  int WIDTH = 16,
    parameter  int DIGIT = 4,
    localparam int N     = WIDTH / DIGIT,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_G_B,
    output logic             A_E_B,
    output logic             A_L_B,
    output logic [CW-1:0]    slices_used
);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    used_q, used_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic [DIGIT-1:0] a_top, b_top;

`ifdef SEQ_MAG_COMP_SIGNED_EN
    // Offset-binary: flipping the sign bit turns a signed order into an unsigned one.
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    assign a_cap = A ^ SIGN_MASK;
    assign b_cap = B ^ SIGN_MASK;
`else
    assign a_cap = A;
    assign b_cap = B;
`endif

    // Operands shift left each step, so the slice under test is always the top DIGIT bits.
    assign a_top = a_q[WIDTH-1 -: DIGIT];
    assign b_top = b_q[WIDTH-1 -: DIGIT];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        used_d  = used_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_cap;
                    b_d     = b_cap;
                    idx_d   = CW'(N - 1);
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (a_top != b_top) begin
                    gt_d    = (a_top > b_top);
                    lt_d    = (a_top < b_top);
                    eq_d    = 1'b0;
                    used_d  = CW'(N) - idx_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    used_d  = CW'(N);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            used_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            used_q  <= used_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign A_G_B       = gt_q;
    assign A_E_B       = eq_q;
    assign A_L_B       = lt_q;
    assign slices_used = used_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb/tb_seq_mag_comp.sv - self-checking bench for seq_mag_comp: vector table, corner sequences, random vs model.
module tb_seq_mag_comp;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             busy, done, A_G_B, A_E_B, A_L_B;
    logic [CW-1:0]    slices_used;

    int errs   = 0;
    int checks = 0;

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .A_G_B(A_G_B), .A_E_B(A_E_B), .A_L_B(A_L_B),
        .slices_used(slices_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  flags;  // {gt, eq, lt}
        int          su;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: order from integer compare; slices used = position of first differing digit from the top.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [2:0] flags, output int su);
        int  av, bv;
        bit  found;
`ifdef SEQ_MAG_COMP_SIGNED_EN
        av = int'($signed(a));
        bv = int'($signed(b));
`else
        av = int'(a);
        bv = int'(b);
`endif
        flags = (av > bv) ? 3'b100 : (av < bv) ? 3'b001 : 3'b010;
        su    = N;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && (((a >> (i * DIGIT)) & 16'hF) != ((b >> (i * DIGIT)) & 16'hF))) begin
                su    = N - i;
                found = 1'b1;
            end
        end
    endfunction

    // Issue a compare from the current sample point and check latency, flags and the single done pulse.
    task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] exp_flags, input int exp_su);
        int n;
        start = 1'b1;
        A = a;
        B = b;
        step();
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        chk({name, ".busy_rise"}, busy, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk({name, ".latency"}, n, exp_su);
        chk({name, ".flags"}, {A_G_B, A_E_B, A_L_B}, exp_flags);
        chk({name, ".slices_used"}, slices_used, exp_su);
        chk({name, ".busy_at_done"}, busy, 1'b0);
        step();
        chk({name, ".done_one_cycle"}, done, 1'b0);
    endtask

    vec_t vecs[10];

    initial begin
        int          n, pulses;
        logic [2:0]  mf;
        int          msu;
        logic [15:0] ra, rb;

        vecs[0] = '{16'h1234, 16'h1234, 3'b010, 4};
        vecs[1] = '{16'h9000, 16'h1FFF, 3'b100, 1};
        vecs[2] = '{16'h12F0, 16'h12F1, 3'b001, 4};
        vecs[3] = '{16'h0100, 16'h0200, 3'b001, 2};
`ifdef SEQ_MAG_COMP_SIGNED_EN
        vecs[4] = '{16'hFFFF, 16'h0000, 3'b001, 1};
        vecs[5] = '{16'h8000, 16'h7FFF, 3'b001, 1};
`else
        vecs[4] = '{16'hFFFF, 16'h0000, 3'b100, 1};
        vecs[5] = '{16'h8000, 16'h7FFF, 3'b100, 1};
`endif
        vecs[6] = '{16'h0000, 16'h0000, 3'b010, 4};
        vecs[7] = '{16'hABCD, 16'hABCE, 3'b001, 4};
        vecs[8] = '{16'h00F0, 16'h0F00, 3'b001, 2};
        vecs[9] = '{16'h1250, 16'h1240, 3'b100, 3};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.flags", {A_G_B, A_E_B, A_L_B}, 3'b000);
        chk("reset.slices_used", slices_used, 0);
        step();

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].su);
            step();
        end

        // start held high while busy with changing operands: only the captured pair counts.
        start  = 1'b1;
        A      = 16'h12F0;
        B      = 16'h12F1;
        step();
        A      = 16'hFFFF;
        B      = 16'h0000;
        n      = 0;
        pulses = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        if (done) pulses++;
        start = 1'b0;
        chk("hold.latency", n, 4);
        chk("hold.flags", {A_G_B, A_E_B, A_L_B}, 3'b001);
        chk("hold.slices_used", slices_used, 4);
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) pulses++;
        end
        chk("hold.done_pulses", pulses, 1);

        // Reset during the second CMP cycle aborts with no done.
        start = 1'b1;
        A     = 16'h0001;
        B     = 16'h0002;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.flags", {A_G_B, A_E_B, A_L_B}, 3'b000);
        chk("abort.slices_used", slices_used, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) pulses++;
        end
        chk("abort.no_done", pulses, 0);

        // Back-to-back: new start accepted in the done cycle.
        start = 1'b1;
        A     = 16'h1234;
        B     = 16'h1234;
        step();
        start = 1'b0;
        n     = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("b2b.first_flags", {A_G_B, A_E_B, A_L_B}, 3'b010);
        run("b2b.second", 16'h0100, 16'h0200, 3'b001, 2);

        // Randomized against the reference model, biased toward long equal prefixes.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = 16'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(0, 15));
            endcase
            model(ra, rb, mf, msu);
            run($sformatf("rand%0d", i), ra, rb, mf, msu);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Parametrised, sequential successor to the team's cascaded 4-bit-slice magnitude comparator.
- Compares two WIDTH-bit operands DIGIT bits per clock, MSB slice first.
- Exits early on the first unequal slice and reports one-hot greater/equal/less with a start/busy/done handshake.
- Used where a wide compare must share a narrow comparison slice, or where compare latency may vary with the data.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per clock (slice width).
- N (localparam), WIDTH/DIGIT, number of slices.
- CW (localparam), $clog2(N+1), width of the slice counter output.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only while idle.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse; result flags valid from this cycle on.
- A_G_B  output  1  A > B.
- A_E_B  output  1  A == B.
- A_L_B  output  1  A < B.
- slices_used  output  CW  number of slices examined for the last result (1..N).

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; busy=0, done=0, A_G_B=0, A_E_B=0, A_L_B=0, slices_used=0; internal operand registers and slice index cleared. rst has priority over everything, including mid-compare; an aborted compare produces no done.
- States: IDLE and CMP.
- IDLE: start=1 at edge E0 captures A and B into internal registers, sets idx=N-1 and busy=1, and moves to CMP. Result flags keep their previous values until the new result is written. done=0 in IDLE except the pulse cycle.
- CMP, each edge: compare slice idx, i.e. bits [idx*DIGIT+DIGIT-1 : idx*DIGIT] of the captured operands.
  - If the slices are unequal: write A_G_B/A_L_B from the slice compare, set A_E_B=0, slices_used=N-idx, done=1, busy=0, go to IDLE.
  - Else if idx==0: A_E_B=1, A_G_B=0, A_L_B=0, slices_used=N, done=1, busy=0, go to IDLE.
  - Else: idx decrements.
- Latency: if the decision is made at edge Ek (k = slices_used), done is high during the cycle after Ek.
  - Equal operands: k=N (4 for defaults).
  - MSB slice differs: k=1.
- done is high for exactly one cycle. Flags hold until the next result or reset.
- After the first result, exactly one of A_G_B/A_E_B/A_L_B is high. All are 0 only after reset.
- start while busy=1 is ignored; the operands do not change.
- start on the same cycle done is high (state already IDLE) is accepted. Back-to-back throughput is therefore k+1 cycles per compare.
- A and B are don't-care except on the accepted-start edge.
- Slice compares are unsigned DIGIT-bit, except as modified below.

Optional Feature:
- Macro: SEQ_MAG_COMP_SIGNED_EN.
- Defined: operands are two's complement. The sign bit (bit WIDTH-1) of both captured operands is inverted before the MSB slice compare (offset-binary), so -1 < 0 and 0x8000 is the minimum for WIDTH=16. Latency and handshake are unchanged.
- Undefined: pure unsigned compare; no sign handling logic is present.

Test Plan (defaults: WIDTH=16, DIGIT=4):
- Reset, then A=0x1234, B=0x1234, start pulse → busy for 4 cycles; done with A_E_B=1, A_G_B=A_L_B=0, slices_used=4.
- A=0x9000, B=0x1FFF, start → done 1 cycle after busy rises; A_G_B=1, slices_used=1.
- A=0x12F0, B=0x12F1, start, with start held high and A/B changed to 0xFFFF/0x0000 while busy → the changes are ignored; A_L_B=1, slices_used=4, and only one done pulse occurs.
- Assert rst in the 2nd CMP cycle of A=0x0001, B=0x0002 → next cycle busy=0, done never pulses, all flags 0, slices_used=0.
- start re-asserted in the done cycle with A=0x0100, B=0x0200 → new compare is accepted immediately; A_L_B=1, slices_used=2.
- SIGNED_EN build: A=0xFFFF (-1), B=0x0000 → A_L_B=1, slices_used=1. Unsigned build with the same stimulus → A_G_B=1.
